router_fifo: RTL and testbench



---
 rtl/router_pkg.sv | 14 +
 rtl/router_fifo_mem.sv | 35 +++
 rtl/router_fifo.sv | 88 ++++++++
 tb/tb_router_fifo.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants: default FIFO geometry and header field layout.
package router_pkg;

   localparam int DEPTH_DEFAULT = 16;
   localparam int WIDTH_DEFAULT = 8;

   // Header byte: payload length in [7:2], destination address in [1:0].
   localparam int HDR_LEN_MSB   = 7;
   localparam int HDR_LEN_LSB   = 2;
   localparam int HDR_ADDR_W    = 2;

   localparam int PKT_CNT_W     = 7;

endpackage

// File: rtl/router_fifo_mem.sv
// Dual-port storage for the port FIFO: sync write, async read, bulk tag clear.
// Entry layout is {hdr_tag, byte}; only the tag bits carry reset.
module router_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH:0]   wdata,
   input  logic             clr_tags,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH:0]   rdata
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] tag;

   // Byte storage; contents are only meaningful between the pointers, so no reset.
   always_ff @(posedge clock) begin
      if (we) data_q[waddr] <= wdata[WIDTH-1:0];
   end

   // Header tags must be cleared on a flush so stale entries never look like headers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)         tag <= '0;
      else if (clr_tags) tag <= '0;
      else if (we)       tag[waddr] <= wdata[WIDTH];
   end

   assign rdata = {tag[raddr], data_q[raddr]};

endmodule

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router. Tags header bytes on write and
// tracks packet length on the read side so the idle bus returns to zero.
module router_fifo
   import router_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;
   localparam logic [PKT_CNT_W-1:0] CNT_ONE = 1;

   logic [AW:0]           wr_ptr, rd_ptr;
   logic                  lfd_d;
   logic [PKT_CNT_W-1:0]  pkt_cnt;
   logic [WIDTH:0]        rd_entry;
   logic                  wr_acc, rd_acc;

   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // soft_reset wins over both ports in its cycle.
   assign wr_acc = write_enb && !full  && !soft_reset;
   assign rd_acc = read_enb  && !empty && !soft_reset;

   router_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_mem (
      .clock    (clock),
      .reset    (reset),
      .we       (wr_acc),
      .waddr    (wr_ptr[AW-1:0]),
      .wdata    ({lfd_d, data_in}),
      .clr_tags (soft_reset),
      .raddr    (rd_ptr[AW-1:0]),
      .rdata    (rd_entry)
   );

   // Header byte trails lfd_state by one clock, so delay the flag to line up.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)           lfd_d <= 1'b0;
      else if (soft_reset) lfd_d <= 1'b0;
      else                 lfd_d <= lfd_state;
   end

   // Pointer advance on accepted transfers; wrap bit falls out of the extra MSB.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (soft_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Registered read data and packet-length tracking; bus idles at zero between packets.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_out <= '0;
         pkt_cnt  <= '0;
      end else if (soft_reset) begin
         data_out <= '0;
         pkt_cnt  <= '0;
      end else if (rd_acc) begin
         data_out <= rd_entry[WIDTH-1:0];
         if (rd_entry[WIDTH])
            pkt_cnt <= PKT_CNT_W'(rd_entry[HDR_LEN_MSB:HDR_LEN_LSB]) + CNT_ONE;
         else if (pkt_cnt != '0)
            pkt_cnt <= pkt_cnt - CNT_ONE;
      end else if (pkt_cnt == '0) begin
         data_out <= '0;
      end
   end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
module tb_router_fifo;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       soft_reset = 1'b0;
   logic       write_enb = 1'b0;
   logic       read_enb = 1'b0;
   logic       lfd_state = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       full, empty;

   int total = 0;
   int bad   = 0;
   logic [7:0] q[$];
   logic [7:0] exp_b;

   router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .read_enb   (read_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .data_out   (data_out),
      .full       (full),
      .empty      (empty)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      write_enb = 1'b1; data_in = b;
      tick();
      write_enb = 1'b0;
   endtask

   task automatic send_hdr(input logic [7:0] h);
      lfd_state = 1'b1;
      tick();
      lfd_state = 1'b0;
      push(h);
   endtask

   task automatic pop();
      read_enb = 1'b1;
      tick();
      read_enb = 1'b0;
   endtask

   initial begin
      logic [7:0] pkt [5];
      pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h2F;

      tick(); tick();
      reset = 1'b0;

      // ---- async reset mid-packet, no clock edge needed
      send_hdr(8'h0D);
      push(8'h11);
      pop();
      reset = 1'b1;
      #2;
      chk("rst_empty",    32'(empty), 32'd1);
      chk("rst_full",     32'(full), 32'd0);
      chk("rst_dout",     32'(data_out), 32'h0);
      chk("rst_pkt_cnt",  32'(dut.pkt_cnt), 32'd0);
      tick();
      reset = 1'b0;

      // ---- single packet
      send_hdr(pkt[0]);
      chk("pkt_empty_deassert", 32'(empty), 32'd0);
      for (int i = 1; i < 5; i++) push(pkt[i]);
      chk("pkt_tag_hdr", 32'(dut.u_mem.tag[0]), 32'd1);
      for (int i = 1; i < 5; i++) chk("pkt_tag_body", 32'(dut.u_mem.tag[i]), 32'd0);
      for (int i = 0; i < 5; i++) begin
         pop();
         chk("pkt_dout", 32'(data_out), 32'(pkt[i]));
         chk("pkt_cnt", 32'(dut.pkt_cnt), 32'(4 - i));
      end
      tick();
      chk("pkt_idle_dout", 32'(data_out), 32'h0);
      chk("pkt_end_empty", 32'(empty), 32'd1);

      // ---- fill, drop on full, recover
      do_reset();
      for (int i = 0; i < 16; i++) begin
         chk("fill_not_full", 32'(full), 32'd0);
         push(8'h10 + 8'(i));
      end
      chk("fill_full", 32'(full), 32'd1);
      push(8'hAA);
      chk("fill_drop_wrptr", 32'(dut.wr_ptr), 32'h10);
      chk("fill_still_full", 32'(full), 32'd1);
      pop();
      chk("fill_first_dout", 32'(data_out), 32'h10);
      chk("fill_full_clr", 32'(full), 32'd0);
      push(8'h55);
      chk("fill_refull", 32'(full), 32'd1);
      for (int i = 1; i < 16; i++) begin
         pop();
         chk("fill_drain", 32'(data_out), 32'(8'h10 + 8'(i)));
      end
      pop();
      chk("fill_last_no_aa", 32'(data_out), 32'h55);
      chk("fill_drained_empty", 32'(empty), 32'd1);

      // ---- wrap with simultaneous access
      do_reset();
      q.delete();
      for (int i = 0; i < 8; i++) begin
         push(8'h80 + 8'(i));
         q.push_back(8'h80 + 8'(i));
      end
      for (int k = 0; k < 20; k++) begin
         read_enb = 1'b1; write_enb = 1'b1; data_in = 8'hC0 + 8'(k);
         tick();
         exp_b = q.pop_front();
         q.push_back(8'hC0 + 8'(k));
         chk("wrap_dout", 32'(data_out), 32'(exp_b));
         chk("wrap_full", 32'(full), 32'd0);
         chk("wrap_empty", 32'(empty), 32'd0);
      end
      read_enb = 1'b0; write_enb = 1'b0;
      chk("wrap_occupancy", 32'(5'(dut.wr_ptr - dut.rd_ptr)), 32'd8);
      chk("wrap_wrptr", 32'(dut.wr_ptr), 32'd28);

      // ---- soft_reset mid-packet
      do_reset();
      send_hdr(8'h0D);
      for (int i = 1; i < 5; i++) push(pkt[i]);
      pop();
      pop();
      chk("srst_pre_cnt", 32'(dut.pkt_cnt), 32'd3);
      soft_reset = 1'b1;
      read_enb = 1'b1;
      write_enb = 1'b1; data_in = 8'h99;
      tick();
      soft_reset = 1'b0; read_enb = 1'b0; write_enb = 1'b0;
      chk("srst_empty", 32'(empty), 32'd1);
      chk("srst_dout", 32'(data_out), 32'h0);
      chk("srst_cnt", 32'(dut.pkt_cnt), 32'd0);
      chk("srst_tags", 32'(dut.u_mem.tag), 32'h0);
      send_hdr(8'h04);
      push(8'h5A);
      push(8'h5E);
      pop();
      chk("srst_hdr_dout", 32'(data_out), 32'h04);
      chk("srst_hdr_cnt", 32'(dut.pkt_cnt), 32'd2);
      pop();
      chk("srst_pay", 32'(data_out), 32'h5A);
      pop();
      chk("srst_par", 32'(data_out), 32'h5E);
      chk("srst_end_cnt", 32'(dut.pkt_cnt), 32'd0);

      // ---- read when empty
      do_reset();
      pop();
      chk("rde_rdptr", 32'(dut.rd_ptr), 32'd0);
      chk("rde_dout", 32'(data_out), 32'h0);
      chk("rde_empty", 32'(empty), 32'd1);

      // ---- empty with simultaneous read/write: no fall-through
      read_enb = 1'b1; write_enb = 1'b1; data_in = 8'h3C;
      tick();
      read_enb = 1'b0; write_enb = 1'b0;
      chk("nofall_dout", 32'(data_out), 32'h0);
      chk("nofall_empty", 32'(empty), 32'd0);
      pop();
      chk("nofall_read", 32'(data_out), 32'h3C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
